// File: rtl/md_hilo_ctrl_pkg.sv
// HI/LO controller shared definitions: op one-hot bit positions, FSM states,
// divider result width and an operand extension helper.
// Optional feature macro: MD_MUL_PIPE_EN (adds the MUL state).
package md_hilo_ctrl_pkg;

  localparam int MD_OP_WD    = 6;
  localparam int DIV_DOUT_WD = 64;

  // one-hot op vector is {mult, multu, div, divu, mthi, mtlo}
  localparam int OP_MULT  = 5;
  localparam int OP_MULTU = 4;
  localparam int OP_DIV   = 3;
  localparam int OP_DIVU  = 2;
  localparam int OP_MTHI  = 1;
  localparam int OP_MTLO  = 0;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ISSUE = 3'd1,
    S_WAIT  = 3'd2,
    S_DRAIN = 3'd3,
    S_DONE  = 3'd4
`ifdef MD_MUL_PIPE_EN
    , S_MUL = 3'd5
`endif
  } md_state_t;

  // Sign- or zero-extend a 32-bit operand to 64 bits so a 64-bit product
  // keeps the exact 33x33 signed result.
  function automatic logic [63:0] ext64(input logic [31:0] v, input logic sgn);
    return {{32{sgn & v[31]}}, v};
  endfunction

endpackage

// File: rtl/md_hilo_ctrl_if.sv
// Divider handshake bundle between the HI/LO controller (master) and the
// signed/unsigned divider IPs owned by EXE (slave).
interface md_hilo_ctrl_if;
  import md_hilo_ctrl_pkg::*;

  logic                   div_s_tvalid;
  logic                   div_s_tready;
  logic                   div_s_dvalid;
  logic [DIV_DOUT_WD-1:0] div_s_dout;
  logic                   div_u_tvalid;
  logic                   div_u_tready;
  logic                   div_u_dvalid;
  logic [DIV_DOUT_WD-1:0] div_u_dout;
  logic [31:0]            div_src1;
  logic [31:0]            div_src2;
  logic                   div_aresetn;

  modport master (
    output div_s_tvalid, div_u_tvalid, div_src1, div_src2, div_aresetn,
    input  div_s_tready, div_s_dvalid, div_s_dout,
    input  div_u_tready, div_u_dvalid, div_u_dout
  );

  modport slave (
    input  div_s_tvalid, div_u_tvalid, div_src1, div_src2, div_aresetn,
    output div_s_tready, div_s_dvalid, div_s_dout,
    output div_u_tready, div_u_dvalid, div_u_dout
  );

endinterface

// File: rtl/md_hilo_ctrl_mul.sv
// md_mul: 33x33 signed multiplier for mult/multu. The 33rd bit carries the
// sign for mult and zero for multu. With MD_MUL_PIPE_EN the product is
// registered once before it leaves the block.
module md_mul
  import md_hilo_ctrl_pkg::*;
(
`ifdef MD_MUL_PIPE_EN
  input  logic        clk,
  input  logic        reset,
`endif
  input  logic [31:0] i_a,
  input  logic [31:0] i_b,
  input  logic        i_signed,
  output logic [63:0] o_prod
);

  logic [63:0] w_prod;

  assign w_prod = ext64(i_a, i_signed) * ext64(i_b, i_signed);

`ifdef MD_MUL_PIPE_EN
  logic [63:0] r_prod;

  // output register: product is consumed one cycle after the operands
  always_ff @(posedge clk) begin
    if (reset) r_prod <= '0;
    else       r_prod <= w_prod;
  end

  assign o_prod = r_prod;
`else
  assign o_prod = w_prod;
`endif

endmodule

// File: rtl/md_hilo_ctrl.sv
// md_hilo_ctrl: owns HI/LO, executes mult/multu/mthi/mtlo and sequences the
// external signed/unsigned dividers (valid/ready in, dout_valid back).
// op_done feeds EXE's ready_go; divider results orphaned by a flush are
// swallowed in DRAIN. Optional macro MD_MUL_PIPE_EN: registered multiply
// through the MUL state.
module md_hilo_ctrl
  import md_hilo_ctrl_pkg::*;
#(
  parameter int DIV_TIMEOUT = 255
)
(
  input  logic                clk,
  input  logic                reset,
  input  logic                i_op_valid,
  input  logic [MD_OP_WD-1:0] i_op,
  input  logic [31:0]         i_src1,
  input  logic [31:0]         i_src2,
  input  logic                i_commit,
  input  logic                i_flush,
  input  logic                i_es_adv,
  output logic                o_op_done,
  output logic [31:0]         o_hi,
  output logic [31:0]         o_lo,
  output logic                o_busy,
  output logic                o_err_timeout,
  md_hilo_ctrl_if.master      div_if
);

  localparam int               TMO_W    = $clog2(DIV_TIMEOUT + 1);
  localparam logic [TMO_W-1:0] TMO_MAX  = TMO_W'(DIV_TIMEOUT);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(DIV_TIMEOUT - 1);

  md_state_t        r_state;
  md_state_t        w_state_next;
  logic [31:0]      r_hi;
  logic [31:0]      r_lo;
  logic             r_div_signed;
  logic [TMO_W-1:0] r_tmo_cnt;
  logic             r_err_timeout;

  logic             w_op_done;
  logic             w_hi_we;
  logic             w_lo_we;
  logic [31:0]      w_hi_wd;
  logic [31:0]      w_lo_wd;
  logic [63:0]      w_mul_prod;
  logic             w_tready;
  logic             w_dvalid;
  logic [63:0]      w_dout;
  logic             w_in_div;
  logic             w_tmo_run;

  md_mul u_mul (
`ifdef MD_MUL_PIPE_EN
    .clk      (clk),
    .reset    (reset),
`endif
    .i_a      (i_src1),
    .i_b      (i_src2),
    .i_signed (i_op[OP_MULT]),
    .o_prod   (w_mul_prod)
  );

  // only the divider chosen at issue time is looked at
  assign w_tready = r_div_signed ? div_if.div_s_tready : div_if.div_u_tready;
  assign w_dvalid = r_div_signed ? div_if.div_s_dvalid : div_if.div_u_dvalid;
  assign w_dout   = r_div_signed ? div_if.div_s_dout   : div_if.div_u_dout;

  assign div_if.div_s_tvalid = (r_state == S_ISSUE) &&  r_div_signed;
  assign div_if.div_u_tvalid = (r_state == S_ISSUE) && !r_div_signed;
  assign div_if.div_src1     = i_src1;
  assign div_if.div_src2     = i_src2;
  assign div_if.div_aresetn  = ~reset;

  assign o_op_done     = w_op_done;
  assign o_hi          = r_hi;
  assign o_lo          = r_lo;
  assign o_busy        = (r_state != S_IDLE);
  assign o_err_timeout = r_err_timeout;

  // state register
  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_next;
  end

  // next state, op_done and HI/LO write selection
  always_comb begin
    w_state_next = r_state;
    w_op_done    = 1'b0;
    w_hi_we      = 1'b0;
    w_lo_we      = 1'b0;
    w_hi_wd      = '0;
    w_lo_wd      = '0;
    case (r_state)
      S_IDLE: begin
        if (i_op_valid && !i_flush) begin
          if (!i_commit) begin
            // squashed op: let EXE move on without touching anything
            w_op_done = 1'b1;
          end else if (i_op[OP_MULT] || i_op[OP_MULTU]) begin
`ifdef MD_MUL_PIPE_EN
            w_state_next = S_MUL;
`else
            w_hi_we   = 1'b1;
            w_lo_we   = 1'b1;
            w_hi_wd   = w_mul_prod[63:32];
            w_lo_wd   = w_mul_prod[31:0];
            w_op_done = 1'b1;
            if (!i_es_adv) w_state_next = S_DONE;
`endif
          end else if (i_op[OP_MTHI] || i_op[OP_MTLO]) begin
            w_hi_we   = i_op[OP_MTHI];
            w_lo_we   = i_op[OP_MTLO];
            w_hi_wd   = i_src1;
            w_lo_wd   = i_src1;
            w_op_done = 1'b1;
            if (!i_es_adv) w_state_next = S_DONE;
          end else if (i_op[OP_DIV] || i_op[OP_DIVU]) begin
            w_state_next = S_ISSUE;
          end
        end
      end
      S_ISSUE: begin
        // an accepted request must be drained even if flushed in the same cycle
        if (w_tready)     w_state_next = i_flush ? S_DRAIN : S_WAIT;
        else if (i_flush) w_state_next = S_IDLE;
      end
      S_WAIT: begin
        if (w_dvalid) begin
          if (i_flush) begin
            w_state_next = S_IDLE;
          end else begin
            w_hi_we      = 1'b1;
            w_lo_we      = 1'b1;
            w_hi_wd      = w_dout[31:0];
            w_lo_wd      = w_dout[63:32];
            w_op_done    = 1'b1;
            w_state_next = i_es_adv ? S_IDLE : S_DONE;
          end
        end else if (i_flush) begin
          w_state_next = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (w_dvalid) w_state_next = S_IDLE;
      end
      S_DONE: begin
        w_op_done = 1'b1;
        if (i_es_adv || i_flush) w_state_next = S_IDLE;
      end
`ifdef MD_MUL_PIPE_EN
      S_MUL: begin
        if (i_flush) begin
          w_state_next = S_IDLE;
        end else begin
          w_hi_we      = 1'b1;
          w_lo_we      = 1'b1;
          w_hi_wd      = w_mul_prod[63:32];
          w_lo_wd      = w_mul_prod[31:0];
          w_op_done    = 1'b1;
          w_state_next = i_es_adv ? S_IDLE : S_DONE;
        end
      end
`endif
      default: w_state_next = S_IDLE;
    endcase
  end

  // HI/LO architectural registers
  always_ff @(posedge clk) begin
    if (reset) begin
      r_hi <= '0;
      r_lo <= '0;
    end else begin
      if (w_hi_we) r_hi <= w_hi_wd;
      if (w_lo_we) r_lo <= w_lo_wd;
    end
  end

  // remember which divider the op in flight belongs to (latched while idle)
  always_ff @(posedge clk) begin
    if (reset)                  r_div_signed <= 1'b0;
    else if (r_state == S_IDLE) r_div_signed <= i_op[OP_DIV];
  end

  assign w_in_div  = (r_state == S_WAIT) || (r_state == S_DRAIN);
  assign w_tmo_run = w_in_div && !w_dvalid;

  // saturating watchdog over WAIT/DRAIN; purely diagnostic, never alters state
  always_ff @(posedge clk) begin
    if (reset) begin
      r_tmo_cnt     <= '0;
      r_err_timeout <= 1'b0;
    end else begin
      r_err_timeout <= w_tmo_run && (r_tmo_cnt == TMO_LAST);
      if (!w_in_div)                              r_tmo_cnt <= '0;
      else if (w_tmo_run && r_tmo_cnt != TMO_MAX) r_tmo_cnt <= r_tmo_cnt + TMO_W'(1);
    end
  end

endmodule

// File: tb/tb_md_hilo_ctrl.sv
// Directed bench for md_hilo_ctrl: the divider IPs are played by the bench
// through the interface; every expected value is hand-computed.
module tb_md_hilo_ctrl;

  localparam logic [5:0] OP_MULT  = 6'b100000;
  localparam logic [5:0] OP_MULTU = 6'b010000;
  localparam logic [5:0] OP_DIV   = 6'b001000;
  localparam logic [5:0] OP_DIVU  = 6'b000100;
  localparam logic [5:0] OP_MTHI  = 6'b000010;
  localparam logic [5:0] OP_MTLO  = 6'b000001;

  logic        clk;
  logic        reset;
  logic        op_valid;
  logic [5:0]  op;
  logic [31:0] src1;
  logic [31:0] src2;
  logic        commit;
  logic        flush;
  logic        es_adv;
  logic        op_done;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        busy;
  logic        err_timeout;

  int n_vec = 0;
  int n_err = 0;

  md_hilo_ctrl_if u_if();

  md_hilo_ctrl #(.DIV_TIMEOUT(255)) dut (
    .clk           (clk),
    .reset         (reset),
    .i_op_valid    (op_valid),
    .i_op          (op),
    .i_src1        (src1),
    .i_src2        (src2),
    .i_commit      (commit),
    .i_flush       (flush),
    .i_es_adv      (es_adv),
    .o_op_done     (op_done),
    .o_hi          (hi),
    .o_lo          (lo),
    .o_busy        (busy),
    .o_err_timeout (err_timeout),
    .div_if        (u_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int first_hit;
    int hits;

    reset = 1'b1; op_valid = 1'b0; op = '0; src1 = '0; src2 = '0;
    commit = 1'b0; flush = 1'b0; es_adv = 1'b0;
    u_if.div_s_tready = 1'b0; u_if.div_s_dvalid = 1'b0; u_if.div_s_dout = '0;
    u_if.div_u_tready = 1'b0; u_if.div_u_dvalid = 1'b0; u_if.div_u_dout = '0;
    cyc(); cyc();
    #1;
    chk("rst_aresetn", u_if.div_aresetn, 0);
    chk("rst_hi", hi, 0);
    chk("rst_lo", lo, 0);
    chk("rst_busy", busy, 0);
    chk("rst_op_done", op_done, 0);
    chk("rst_s_tvalid", u_if.div_s_tvalid, 0);
    chk("rst_err", err_timeout, 0);
    reset = 1'b0;
    #1;
    chk("aresetn_released", u_if.div_aresetn, 1);
    cyc();

    // mult FFFFFFFF * 2 (signed: -2)
    op_valid = 1'b1; op = OP_MULT; src1 = 32'hFFFFFFFF; src2 = 32'h2; commit = 1'b1; es_adv = 1'b1;
`ifdef MD_MUL_PIPE_EN
    #1; chk("mult_done_c0", op_done, 0);
    cyc(); chk("mult_busy_mul", busy, 1);
`endif
    #1; chk("mult_done", op_done, 1);
    cyc();
    chk("mult_hi", hi, 32'hFFFFFFFF);
    chk("mult_lo", lo, 32'hFFFFFFFE);
    chk("mult_busy", busy, 0);
    $display("txn mult  hi=%h lo=%h", hi, lo);

    // multu same operands
    op = OP_MULTU;
`ifdef MD_MUL_PIPE_EN
    #1; chk("multu_done_c0", op_done, 0);
    cyc();
`endif
    #1; chk("multu_done", op_done, 1);
    cyc();
    chk("multu_hi", hi, 32'h00000001);
    chk("multu_lo", lo, 32'hFFFFFFFE);
    $display("txn multu hi=%h lo=%h", hi, lo);

    // mthi with es_adv low for two cycles
    op = OP_MTHI; src1 = 32'h12345678; es_adv = 1'b0;
    #1; chk("mthi_done_c0", op_done, 1);
    cyc(); chk("mthi_hi_c0", hi, 32'h12345678); chk("mthi_busy_c0", busy, 1);
    #1; chk("mthi_done_c1", op_done, 1);
    cyc(); chk("mthi_lo_c1", lo, 32'hFFFFFFFE); chk("mthi_busy_c1", busy, 1);
    es_adv = 1'b1;
    #1; chk("mthi_done_c2", op_done, 1);
    cyc(); chk("mthi_busy_end", busy, 0);
    $display("txn mthi  hi=%h lo=%h", hi, lo);

    // mtlo with es_adv low for two cycles
    op = OP_MTLO; src1 = 32'h9ABCDEF0; es_adv = 1'b0;
    #1; chk("mtlo_done_c0", op_done, 1);
    cyc(); chk("mtlo_lo_c0", lo, 32'h9ABCDEF0);
    #1; chk("mtlo_done_c1", op_done, 1);
    cyc(); chk("mtlo_busy_c1", busy, 1);
    es_adv = 1'b1;
    #1; cyc();
    chk("mtlo_hi_final", hi, 32'h12345678);
    chk("mtlo_lo_final", lo, 32'h9ABCDEF0);
    chk("mtlo_busy_end", busy, 0);
    $display("txn mtlo  hi=%h lo=%h", hi, lo);

    // div -7 / 2, tready low for 3 cycles, dvalid 10 cycles after acceptance
    op = OP_DIV; src1 = 32'hFFFFFFF9; src2 = 32'h2; es_adv = 1'b0; u_if.div_s_tready = 1'b0;
    #1; chk("div_idle_done", op_done, 0); chk("div_idle_tvalid", u_if.div_s_tvalid, 0);
    cyc(); chk("div_busy", busy, 1);
    for (int i = 0; i < 4; i++) begin
      if (i == 3) u_if.div_s_tready = 1'b1;
      #1;
      chk("div_issue_tvalid", u_if.div_s_tvalid, 1);
      chk("div_issue_u_tvalid", u_if.div_u_tvalid, 0);
      chk("div_issue_src1", u_if.div_src1, 32'hFFFFFFF9);
      chk("div_issue_src2", u_if.div_src2, 32'h2);
      chk("div_issue_done", op_done, 0);
      cyc();
    end
    u_if.div_s_tready = 1'b0;
    for (int i = 0; i < 9; i++) begin
      #1;
      chk("div_wait_done", op_done, 0);
      chk("div_wait_tvalid", u_if.div_s_tvalid, 0);
      chk("div_wait_lo", lo, 32'h9ABCDEF0);
      cyc();
    end
    u_if.div_s_dvalid = 1'b1; u_if.div_s_dout = {32'hFFFFFFFD, 32'hFFFFFFFF}; es_adv = 1'b1;
    #1; chk("div_dvalid_done", op_done, 1);
    cyc();
    u_if.div_s_dvalid = 1'b0; u_if.div_s_dout = '0;
    chk("div_lo", lo, 32'hFFFFFFFD);
    chk("div_hi", hi, 32'hFFFFFFFF);
    chk("div_busy_end", busy, 0);
    $display("txn div   hi=%h lo=%h", hi, lo);

    // divu 7/0 flushed in WAIT, followed by divu 9/2 that must wait behind DRAIN
    op = OP_DIVU; src1 = 32'd7; src2 = 32'd0; es_adv = 1'b0; u_if.div_u_tready = 1'b1;
    #1; chk("divu0_idle_done", op_done, 0);
    cyc();
    #1; chk("divu0_u_tvalid", u_if.div_u_tvalid, 1); chk("divu0_s_tvalid", u_if.div_s_tvalid, 0);
    cyc();
    u_if.div_u_tready = 1'b0;
    flush = 1'b1;
    #1; chk("divu0_flush_done", op_done, 0);
    cyc();
    flush = 1'b0;
    op = OP_DIVU; src1 = 32'd9; src2 = 32'd2; op_valid = 1'b1; commit = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("drain_done", op_done, 0);
      chk("drain_u_tvalid", u_if.div_u_tvalid, 0);
      chk("drain_busy", busy, 1);
      cyc();
      chk("drain_hi", hi, 32'hFFFFFFFF);
      chk("drain_lo", lo, 32'hFFFFFFFD);
    end
    u_if.div_u_dvalid = 1'b1; u_if.div_u_dout = {32'hFFFFFFFF, 32'h00000007};
    #1; chk("drain_dvalid_done", op_done, 0);
    cyc();
    u_if.div_u_dvalid = 1'b0; u_if.div_u_dout = '0;
    chk("drain_disc_hi", hi, 32'hFFFFFFFF);
    chk("drain_disc_lo", lo, 32'hFFFFFFFD);
    chk("drain_to_idle", busy, 0);
    $display("txn divu 7/0 flushed, result discarded");
    u_if.div_u_tready = 1'b1;
    #1; chk("divu1_idle_done", op_done, 0);
    cyc();
    #1; chk("divu1_tvalid", u_if.div_u_tvalid, 1); chk("divu1_src1", u_if.div_src1, 32'd9);
    cyc();
    u_if.div_u_tready = 1'b0;
    u_if.div_u_dvalid = 1'b1; u_if.div_u_dout = {32'd4, 32'd1}; es_adv = 1'b1;
    #1; chk("divu1_done", op_done, 1);
    cyc();
    u_if.div_u_dvalid = 1'b0; u_if.div_u_dout = '0;
    chk("divu1_lo", lo, 32'd4);
    chk("divu1_hi", hi, 32'd1);
    $display("txn divu 9/2 hi=%h lo=%h", hi, lo);

    // div with commit=0 is a no-op that completes immediately
    op = OP_DIV; src1 = 32'd100; src2 = 32'd3; commit = 1'b0; es_adv = 1'b1;
    #1; chk("nocommit_done", op_done, 1); chk("nocommit_tvalid", u_if.div_s_tvalid, 0);
    cyc();
    chk("nocommit_busy", busy, 0); chk("nocommit_hi", hi, 32'd1); chk("nocommit_lo", lo, 32'd4);
    #1; chk("nocommit_tvalid_c1", u_if.div_s_tvalid, 0);
    $display("txn div uncommitted, no effect");

    // flush while waiting for tready: request withdrawn
    commit = 1'b1; es_adv = 1'b0; u_if.div_s_tready = 1'b0;
    cyc();
    #1; chk("issflush_tvalid", u_if.div_s_tvalid, 1);
    flush = 1'b1;
    cyc();
    flush = 1'b0; op_valid = 1'b0;
    chk("issflush_idle", busy, 0);
    #1; chk("issflush_tvalid_off", u_if.div_s_tvalid, 0);
    $display("txn div flushed before acceptance");

    // divider never answers: single err_timeout pulse after 255 WAIT cycles
    op_valid = 1'b1; op = OP_DIVU; src1 = 32'd1; src2 = 32'd1; u_if.div_u_tready = 1'b1;
    cyc(); cyc();
    u_if.div_u_tready = 1'b0;
    first_hit = -1;
    hits = 0;
    for (int n = 1; n <= 300; n++) begin
      cyc();
      if (err_timeout) begin
        hits++;
        if (first_hit < 0) first_hit = n;
      end
    end
    chk("tmo_first_cycle", first_hit, 255);
    chk("tmo_pulse_count", hits, 1);
    chk("tmo_still_busy", busy, 1);
    u_if.div_u_dvalid = 1'b1; u_if.div_u_dout = {32'd1, 32'd0}; es_adv = 1'b1;
    #1; chk("tmo_late_done", op_done, 1);
    cyc();
    u_if.div_u_dvalid = 1'b0; u_if.div_u_dout = '0;
    chk("tmo_lo", lo, 32'd1); chk("tmo_hi", hi, 32'd0);
    $display("txn divu with timeout pulse, hi=%h lo=%h", hi, lo);

    // reset while a div is in WAIT; the late dvalid must not reach HI/LO
    op = OP_DIV; src1 = 32'd20; src2 = 32'd3; es_adv = 1'b0; u_if.div_s_tready = 1'b1;
    cyc(); cyc();
    u_if.div_s_tready = 1'b0;
    reset = 1'b1;
    #1; chk("wrst_aresetn", u_if.div_aresetn, 0);
    cyc();
    chk("wrst_busy", busy, 0); chk("wrst_hi", hi, 0); chk("wrst_lo", lo, 0);
    reset = 1'b0; op_valid = 1'b0;
    u_if.div_s_dvalid = 1'b1; u_if.div_s_dout = {32'd6, 32'd2};
    #1; chk("wrst_stale_done", op_done, 0);
    cyc();
    u_if.div_s_dvalid = 1'b0; u_if.div_s_dout = '0;
    chk("wrst_stale_hi", hi, 0); chk("wrst_stale_lo", lo, 0); chk("wrst_stale_busy", busy, 0);
    $display("txn reset in WAIT, hi=%h lo=%h", hi, lo);

    cyc();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
